// File: rtl/bbox_scanner_pkg.sv
// Shared definitions for the triangle raster pipeline: coordinate types,
// default screen limits and the scanner state encoding.
package bbox_scanner_pkg;

    localparam int COORD_W   = 12;
    localparam int DEF_MAX_X = 40;
    localparam int DEF_MAX_Y = 50;

    typedef logic [COORD_W-1:0]   coord_t;
    typedef logic [2*COORD_W-1:0] count_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BOX  = 2'd1,
        SCAN = 2'd2,
        DONE = 2'd3
    } scan_state_e;

    // Clamp a coordinate to the last valid screen position
    function automatic coord_t clip_coord(input coord_t v, input coord_t lim);
        coord_t r;
        if (v > lim) begin
            r = lim;
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/bbox_scanner_if.sv
// Triangle-in / pixel-out handshake bundle of the bounding-box scanner.
// master = environment (triangle producer and pixel consumer), slave = scanner.
interface bbox_scanner_if
    import bbox_scanner_pkg::*;
();
    logic   tri_valid;
    logic   tri_ready;
    coord_t tri_p1x, tri_p1y, tri_p2x, tri_p2y, tri_p3x, tri_p3y;
    coord_t v_p1x, v_p1y, v_p2x, v_p2y, v_p3x, v_p3y;
    logic   pix_valid;
    logic   pix_ready;
    coord_t pix_x, pix_y;
    logic   pix_first;
    logic   pix_last;
    logic   tri_done;
    count_t pix_count;

    modport master (
        output tri_valid, tri_p1x, tri_p1y, tri_p2x, tri_p2y, tri_p3x, tri_p3y,
        output pix_ready,
        input  tri_ready, v_p1x, v_p1y, v_p2x, v_p2y, v_p3x, v_p3y,
        input  pix_valid, pix_x, pix_y, pix_first, pix_last, tri_done, pix_count
    );

    modport slave (
        input  tri_valid, tri_p1x, tri_p1y, tri_p2x, tri_p2y, tri_p3x, tri_p3y,
        input  pix_ready,
        output tri_ready, v_p1x, v_p1y, v_p2x, v_p2y, v_p3x, v_p3y,
        output pix_valid, pix_x, pix_y, pix_first, pix_last, tri_done, pix_count
    );
endinterface

// File: rtl/bbox_scanner_min_max3.sv
// Combinational minimum and maximum of three unsigned coordinates.
module min_max3
    import bbox_scanner_pkg::*;
(
    input  coord_t a,
    input  coord_t b,
    input  coord_t c,
    output coord_t min_s,
    output coord_t max_s
);
    coord_t min_ab_s;
    coord_t max_ab_s;

    // Pairwise reduction of the three inputs to their extremes
    always_comb begin
        min_ab_s = (b < a) ? b : a;
        max_ab_s = (b > a) ? b : a;
        min_s    = (c < min_ab_s) ? c : min_ab_s;
        max_s    = (c > max_ab_s) ? c : max_ab_s;
    end
endmodule

// File: rtl/bbox_scanner.sv
// Bounding-box scanner: takes one triangle, clips its bounding box to the
// screen and streams every pixel of the box in row-major order.
module bbox_scanner
    import bbox_scanner_pkg::*;
#(
    parameter int MAX_X = DEF_MAX_X,
    parameter int MAX_Y = DEF_MAX_Y
) (
    input logic          Clock,
    input logic          Reset,
    bbox_scanner_if.slave bus
);
    localparam coord_t XLIM_C      = coord_t'(MAX_X);
    localparam coord_t YLIM_C      = coord_t'(MAX_Y);
    localparam coord_t COORD_ONE_C = coord_t'(1);
    localparam count_t COUNT_ONE_C = count_t'(1);

    scan_state_e state_r, next_state_s;

    coord_t xmin_s, xmax_s, ymin_s, ymax_s;
    coord_t xmax_clip_s, ymax_clip_s;
    coord_t xmin_r, xmax_r, ymax_r;
    coord_t cx_r, cy_r, nx_s, ny_s;
    logic   accept_s, hs_s, empty_s, at_last_s, box_single_s;

    // The box is derived from the held vertices, so it is ready one cycle after accept
    min_max3 u_mm_x (.a(bus.v_p1x), .b(bus.v_p2x), .c(bus.v_p3x), .min_s(xmin_s), .max_s(xmax_s));
    min_max3 u_mm_y (.a(bus.v_p1y), .b(bus.v_p2y), .c(bus.v_p3y), .min_s(ymin_s), .max_s(ymax_s));

    assign xmax_clip_s  = clip_coord(xmax_s, XLIM_C);
    assign ymax_clip_s  = clip_coord(ymax_s, YLIM_C);
    assign box_single_s = (xmin_s == xmax_clip_s) && (ymin_s == ymax_clip_s);
    assign bus.pix_x    = cx_r;
    assign bus.pix_y    = cy_r;

    // Next-state decode plus the row-major advance of the scan cursor
    always_comb begin
        next_state_s = state_r;
        accept_s     = 1'b0;
        hs_s         = 1'b0;
        empty_s      = (xmin_s > XLIM_C) || (ymin_s > YLIM_C);
        at_last_s    = (cx_r == xmax_r) && (cy_r == ymax_r);
        nx_s         = cx_r;
        ny_s         = cy_r;
        case (state_r)
            IDLE: begin
                accept_s = bus.tri_valid && bus.tri_ready;
                if (accept_s) begin
                    next_state_s = BOX;
                end else begin
                    next_state_s = IDLE;
                end
            end
            BOX: begin
                if (empty_s) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = SCAN;
                end
            end
            SCAN: begin
                hs_s = bus.pix_valid && bus.pix_ready;
                if (!hs_s) begin
                    next_state_s = SCAN;
                end else if (at_last_s) begin
                    next_state_s = DONE;
                end else if (cx_r < xmax_r) begin
                    next_state_s = SCAN;
                    nx_s         = cx_r + COORD_ONE_C;
                end else begin
                    next_state_s = SCAN;
                    nx_s         = xmin_r;
                    ny_s         = cy_r + COORD_ONE_C;
                end
            end
            DONE: begin
                next_state_s = IDLE;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Registered outputs, held vertices, box limits, scan cursor and pixel count
    always_ff @(posedge Clock) begin
        if (Reset) begin
            bus.tri_ready <= 1'b0;
            bus.pix_valid <= 1'b0;
            bus.pix_first <= 1'b0;
            bus.pix_last  <= 1'b0;
            bus.tri_done  <= 1'b0;
            bus.pix_count <= '0;
            bus.v_p1x     <= '0;
            bus.v_p1y     <= '0;
            bus.v_p2x     <= '0;
            bus.v_p2y     <= '0;
            bus.v_p3x     <= '0;
            bus.v_p3y     <= '0;
            cx_r          <= '0;
            cy_r          <= '0;
            xmin_r        <= '0;
            xmax_r        <= '0;
            ymax_r        <= '0;
        end else begin
            bus.tri_ready <= (next_state_s == IDLE);
            bus.pix_valid <= (next_state_s == SCAN);
            bus.tri_done  <= (next_state_s == DONE);
            if (accept_s) begin
                bus.v_p1x     <= bus.tri_p1x;
                bus.v_p1y     <= bus.tri_p1y;
                bus.v_p2x     <= bus.tri_p2x;
                bus.v_p2y     <= bus.tri_p2y;
                bus.v_p3x     <= bus.tri_p3x;
                bus.v_p3y     <= bus.tri_p3y;
                bus.pix_count <= '0;
            end
            if ((state_r == BOX) && !empty_s) begin
                xmin_r        <= xmin_s;
                xmax_r        <= xmax_clip_s;
                ymax_r        <= ymax_clip_s;
                cx_r          <= xmin_s;
                cy_r          <= ymin_s;
                bus.pix_first <= 1'b1;
                bus.pix_last  <= box_single_s;
            end else if (hs_s) begin
                bus.pix_count <= bus.pix_count + COUNT_ONE_C;
                cx_r          <= nx_s;
                cy_r          <= ny_s;
                bus.pix_first <= 1'b0;
                bus.pix_last  <= !at_last_s && (nx_s == xmax_r) && (ny_s == ymax_r);
            end
        end
    end
endmodule

// File: tb/tb_bbox_scanner.sv
// Bench for bbox_scanner: expected pixel streams come from a plain
// bounding-box enumeration; a monitor pops and compares every handshake.
module tb_bbox_scanner;

    typedef struct {
        int x;
        int y;
        bit first;
        bit last;
    } pix_t;

    localparam int SCR_X = 40;
    localparam int SCR_Y = 50;

    logic Clock = 1'b0;
    logic Reset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   hs_cnt = 0;
    int   ready_mode = 0;
    pix_t pix_q[$];
    int   cnt_q[$];

    always #5 Clock = ~Clock;

    bbox_scanner_if bus ();

    bbox_scanner dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: every pixel of the screen-clipped bounding box, row-major
    function automatic int build_expect(input int x1, y1, x2, y2, x3, y3);
        int xlo, xhi, ylo, yhi, n, k;
        pix_t p;
        xlo = (x1 < x2) ? x1 : x2;  xlo = (x3 < xlo) ? x3 : xlo;
        xhi = (x1 > x2) ? x1 : x2;  xhi = (x3 > xhi) ? x3 : xhi;
        ylo = (y1 < y2) ? y1 : y2;  ylo = (y3 < ylo) ? y3 : ylo;
        yhi = (y1 > y2) ? y1 : y2;  yhi = (y3 > yhi) ? y3 : yhi;
        if (xhi > SCR_X) xhi = SCR_X;
        if (yhi > SCR_Y) yhi = SCR_Y;
        if (xlo > SCR_X || ylo > SCR_Y) return 0;
        n = (xhi - xlo + 1) * (yhi - ylo + 1);
        k = 0;
        for (int y = ylo; y <= yhi; y++) begin
            for (int x = xlo; x <= xhi; x++) begin
                p.x = x; p.y = y; p.first = (k == 0); p.last = (k == n - 1);
                pix_q.push_back(p);
                k++;
            end
        end
        return n;
    endfunction

    // Consumer ready pattern: always, alternating, or random
    always @(posedge Clock) begin
        #1;
        case (ready_mode)
            0:       bus.pix_ready = 1'b1;
            1:       bus.pix_ready = (bus.pix_ready === 1'b1) ? 1'b0 : 1'b1;
            default: bus.pix_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: pixel scoreboard, stall stability and end-of-triangle count
    logic       prev_stall = 1'b0;
    logic [25:0] held;
    always @(negedge Clock) begin
        pix_t e;
        if (Reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", bus.pix_valid, 1);
                check("stall_hold", {bus.pix_x, bus.pix_y, bus.pix_first, bus.pix_last}, held);
            end
            if (bus.pix_valid && bus.pix_ready) begin
                hs_cnt++;
                if (pix_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_pixel: got (%0d,%0d) expected none", bus.pix_x, bus.pix_y);
                end else begin
                    e = pix_q.pop_front();
                    check("pix_x", bus.pix_x, e.x);
                    check("pix_y", bus.pix_y, e.y);
                    check("pix_first", bus.pix_first, e.first);
                    check("pix_last", bus.pix_last, e.last);
                end
            end
            prev_stall = bus.pix_valid && !bus.pix_ready;
            held = {bus.pix_x, bus.pix_y, bus.pix_first, bus.pix_last};
            if (bus.tri_done) begin
                if (cnt_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_tri_done: got 1 expected 0 at %0t", $time);
                end else begin
                    check("pix_count", bus.pix_count, cnt_q.pop_front());
                    check("done_after_last", pix_q.size(), 0);
                end
            end
        end
    end

    // Offer a triangle, then check accept, BOX cycle and first-beat latency
    task automatic start_tri(input int x1, y1, x2, y2, x3, y3, input int mode);
        int n, t;
        ready_mode = mode;
        t = 0;
        while (bus.tri_ready !== 1'b1 && t < 100) begin
            @(posedge Clock); #2; t++;
        end
        check("tri_ready_wait", bus.tri_ready, 1);
        n = build_expect(x1, y1, x2, y2, x3, y3);
        cnt_q.push_back(n);
        bus.tri_valid = 1'b1;
        bus.tri_p1x = 12'(x1); bus.tri_p1y = 12'(y1);
        bus.tri_p2x = 12'(x2); bus.tri_p2y = 12'(y2);
        bus.tri_p3x = 12'(x3); bus.tri_p3y = 12'(y3);
        @(posedge Clock); #2;
        bus.tri_valid = 1'b0;
        bus.tri_p1x = 12'($urandom); bus.tri_p3y = 12'($urandom);
        check("box_ready_low", bus.tri_ready, 0);
        check("box_no_pix", bus.pix_valid, 0);
        check("latch_p1x", bus.v_p1x, x1);
        check("latch_p3y", bus.v_p3y, y3);
        @(posedge Clock); #2;
        if (n == 0) begin
            check("empty_done_latency", bus.tri_done, 1);
            check("empty_no_pix", bus.pix_valid, 0);
        end else begin
            check("first_pix_latency", bus.pix_valid, 1);
        end
    endtask

    // Wait (bounded) for tri_done, then check the pulse width and return to IDLE
    task automatic finish_tri();
        int t;
        t = 0;
        while (bus.tri_done !== 1'b1 && t < 20000) begin
            @(posedge Clock); #2; t++;
        end
        check("tri_done_seen", bus.tri_done, 1);
        @(posedge Clock); #2;
        check("done_pulse", bus.tri_done, 0);
        check("ready_after_done", bus.tri_ready, 1);
    endtask

    initial begin
        int t, bx, by;
        bus.tri_valid = 1'b0;
        bus.tri_p1x = '0; bus.tri_p1y = '0; bus.tri_p2x = '0;
        bus.tri_p2y = '0; bus.tri_p3x = '0; bus.tri_p3y = '0;
        repeat (3) @(posedge Clock);
        #2;
        check("rst_tri_ready", bus.tri_ready, 0);
        check("rst_pix_valid", bus.pix_valid, 0);
        check("rst_tri_done", bus.tri_done, 0);
        check("rst_pix_xy", {bus.pix_x, bus.pix_y, bus.pix_first, bus.pix_last}, 0);
        check("rst_pix_count", bus.pix_count, 0);
        check("rst_v_p2x", bus.v_p2x, 0);
        Reset = 1'b0;
        @(posedge Clock); #2;
        check("ready_after_reset", bus.tri_ready, 1);

        start_tri(10, 10, 10, 30, 30, 20, 0);  finish_tri();
        start_tri(10, 10, 10, 30, 30, 20, 1);  finish_tri();
        start_tri(35, 45, 60, 45, 35, 70, 0);  finish_tri();
        start_tri(41, 0, 50, 5, 60, 9, 0);     finish_tri();
        start_tri(5, 5, 5, 5, 5, 5, 0);        finish_tri();

        // Reset in the middle of a scan discards the triangle
        hs_cnt = 0;
        start_tri(10, 10, 10, 30, 30, 20, 0);
        t = 0;
        while (hs_cnt < 100 && t < 1000) begin
            @(posedge Clock); #2; t++;
        end
        check("reached_100_pixels", (hs_cnt >= 100), 1);
        Reset = 1'b1;
        @(posedge Clock); #2;
        pix_q.delete();
        cnt_q.delete();
        check("midrst_pix_valid", bus.pix_valid, 0);
        check("midrst_tri_done", bus.tri_done, 0);
        check("midrst_tri_ready", bus.tri_ready, 0);
        check("midrst_pix_count", bus.pix_count, 0);
        check("midrst_v_p1x", bus.v_p1x, 0);
        @(posedge Clock); #2;
        Reset = 1'b0;
        @(posedge Clock); #2;
        check("midrst_ready_back", bus.tri_ready, 1);
        start_tri(3, 7, 9, 2, 6, 12, 2);       finish_tri();

        // Random small triangles near and beyond the screen edges
        for (int i = 0; i < 12; i++) begin
            bx = $urandom_range(0, 45);
            by = $urandom_range(0, 55);
            start_tri(bx + $urandom_range(0, 12), by + $urandom_range(0, 12),
                      bx + $urandom_range(0, 12), by + $urandom_range(0, 12),
                      bx + $urandom_range(0, 12), by + $urandom_range(0, 12), 2);
            finish_tri();
        end

        repeat (3) @(posedge Clock);
        #2;
        check("all_pixels_consumed", pix_q.size(), 0);
        check("all_counts_consumed", cnt_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit so the run always terminates
    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/bbox_scanner.md
# bbox_scanner

Upstream feeder of the point-in-triangle test stage. Accepts one triangle (three 12-bit vertices) over a valid/ready handshake, computes its bounding box clipped to the screen, and streams every pixel coordinate of that box in row-major order over a second valid/ready handshake, together with held copies of the vertices. This replaces free-running line/column counters, so the inside test only sees candidate pixels.

## Interface

- COORD_W, 12, coordinate width (unsigned)
- MAX_X, 40, last valid screen column (inclusive)
- MAX_Y, 50, last valid screen line (inclusive)
- Clock  in  1  single clock, all logic on posedge
- Reset  in  1  synchronous, active-high
- tri_valid  in  1  triangle offered
- tri_ready  out  1  triangle accepted when tri_valid && tri_ready
- tri_p1x, tri_p1y, tri_p2x, tri_p2y, tri_p3x, tri_p3y  in  COORD_W each  vertex inputs, sampled on accept
- v_p1x … v_p3y  out  COORD_W each  registered vertices, stable from accept until next accept
- pix_valid  out  1  pixel coordinate offered
- pix_ready  in  1  consumer takes pixel when pix_valid && pix_ready
- pix_x, pix_y  out  COORD_W  pixel coordinate (column, line)
- pix_first  out  1  first pixel of this triangle
- pix_last  out  1  last pixel of this triangle
- tri_done  out  1  one-cycle pulse, triangle finished
- pix_count  out  2*COORD_W  pixels handshaken for current triangle; valid while tri_done=1

## Operation

- States: IDLE, BOX, SCAN, DONE.
- IDLE: tri_ready=1. On accept: latch vertices into v_*, clear pix_count, go BOX.
- BOX (1 cycle): xmin=min3(x), xmax=min(max3(x),MAX_X), ymin, ymax likewise. Empty if xmin>MAX_X or ymin>MAX_Y → DONE. Else load cx=xmin, cy=ymin → SCAN.
- SCAN: pix_valid=1, pix_x=cx, pix_y=cy. On handshake: pix_count+1; if cx<xmax then cx+1; else cx=xmin, cy+1; if cx==xmax && cy==ymax → DONE.
- pix_first = (cx==xmin && cy==ymin); pix_last = (cx==xmax && cy==ymax). Single-pixel box: both 1 on same beat.
- DONE (1 cycle): tri_done=1, → IDLE.
- Arithmetic unsigned throughout; no wrap possible since cx≤xmax≤MAX_X<2^COORD_W-1. Coordinates above MAX_X/MAX_Y clipped, never emitted.
- Degenerate (collinear/coincident) triangles are scanned normally; inside test decides.

## Timing

- Reset: state IDLE; tri_ready=0 while Reset=1, 1 first cycle after Reset deasserts; pix_valid, pix_first, pix_last, tri_done =0; pix_x, pix_y, pix_count, v_* =0.
- Latency: accept in cycle N → BOX in N+1 → first pix_valid in N+2.
- Throughput: one pixel per cycle with pix_ready held 1.
- pix_x/pix_y/pix_first/pix_last stable while pix_valid && !pix_ready; pix_valid never drops before handshake.
- Last handshake in cycle M → tri_done=1 in M+1 → tri_ready=1 in M+2. Empty box: tri_done in N+2, tri_ready in N+3.
- tri_ready=0 outside IDLE; tri_valid ignored there.
- Reset mid-triangle: next cycle IDLE, outputs as reset values; partial triangle discarded, no tri_done.

## Structure

- Shared package: state enum (IDLE, BOX, SCAN, DONE), COORD_W default, MAX_X/MAX_Y defaults, shared with the inside-test and row-scan stages.
- One sub-module: min_max3 (combinational min and max of three COORD_W values), instanced twice (x, y).

## Test plan

- Triangle (10,10),(10,30),(30,20), pix_ready=1 → box x10..30, y10..30; 441 pixels, first (10,10) with pix_first, last (30,30) with pix_last, pix_count=441, first pix_valid 2 cycles after accept.
- Same triangle, pix_ready toggling 1/0 each cycle → identical 441-pixel sequence, outputs stable during stalls, tri_done only after last handshake.
- (35,45),(60,45),(35,70) → clipped x35..40, y45..50; 36 pixels, last (40,50).
- (41,0),(50,5),(60,9) → no pix_valid, tri_done 2 cycles after accept, pix_count=0, tri_ready back next cycle.
- (5,5)×3 → single pixel (5,5) with pix_first=pix_last=1, pix_count=1.
- Reset asserted after 100 pixels of first triangle → pix_valid=0 next cycle, no tri_done, tri_ready=1 first cycle after Reset deasserts; new triangle then scans from its first pixel.
